// File: rtl/edge_level_gen.sv
// edge_level_gen: rebuilds a glitch-free level from rise/fall request pulses.
// Each level is held at least MIN_HOLD cycles; one opposite-direction request
// can be queued while holding. Intended to drive a line that is edge-detected
// again on the receive side.
module edge_level_gen #(
   parameter int MIN_HOLD   = 4,
   parameter bit INIT_LEVEL = 1'b0,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_s0,
   input  logic             in_s1,
   output logic             out_s,
   output logic             busy,
   output logic             err_drop,
   output logic [CNT_W-1:0] edge_cnt
);

   localparam int HOLD_W = (MIN_HOLD < 1) ? 1 : $clog2(MIN_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

   typedef enum logic [1:0] {
      ST_LOW     = 2'd0,
      ST_HOLD_HI = 2'd1,
      ST_HIGH    = 2'd2,
      ST_HOLD_LO = 2'd3
   } state_t;

   localparam state_t ST_INIT = INIT_LEVEL ? ST_HIGH : ST_LOW;

   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   // pending always means "the edge opposite to the level currently held"
   logic              pend_q, pend_d;
   logic              out_s_q, out_s_d;
   logic              busy_q, busy_d;
   logic              err_drop_q, err_drop_d;
   logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
   logic              issue_s;
   logic              drop_s;

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         hold_q     <= HOLD_ZERO;
         pend_q     <= 1'b0;
         out_s_q    <= INIT_LEVEL;
         busy_q     <= 1'b0;
         err_drop_q <= 1'b0;
         edge_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         pend_q     <= pend_d;
         out_s_q    <= out_s_d;
         busy_q     <= busy_d;
         err_drop_q <= err_drop_d;
         edge_cnt_q <= edge_cnt_d;
      end
   end

   // Next-state logic: issue edges, run the hold timer, queue or drop requests
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      pend_d  = pend_q;
      issue_s = 1'b0;
      drop_s  = 1'b0;
      case (state_q)
         ST_LOW: begin
            if (in_s0) begin
               state_d = ST_HOLD_HI;
               hold_d  = HOLD_LOAD;
               issue_s = 1'b1;
               pend_d  = in_s1;
            end else begin
               pend_d  = 1'b0;
            end
         end
         ST_HIGH: begin
            if (in_s1) begin
               state_d = ST_HOLD_LO;
               hold_d  = HOLD_LOAD;
               issue_s = 1'b1;
               pend_d  = in_s0;
            end else begin
               pend_d  = 1'b0;
            end
         end
         ST_HOLD_HI: begin
            if (hold_q == HOLD_ZERO) begin
               // Hold expired: a queued fall or one arriving now is issued;
               // a rise arriving now is judged against the new (empty) queue.
               if (pend_q || in_s1) begin
                  state_d = ST_HOLD_LO;
                  hold_d  = HOLD_LOAD;
                  issue_s = 1'b1;
                  pend_d  = in_s0;
               end else begin
                  state_d = ST_HIGH;
                  pend_d  = 1'b0;
               end
            end else begin
               hold_d = hold_q - HOLD_ONE;
               if (pend_q) begin
                  drop_s = in_s0 | in_s1;
               end else begin
                  pend_d = in_s1;
               end
            end
         end
         ST_HOLD_LO: begin
            if (hold_q == HOLD_ZERO) begin
               if (pend_q || in_s0) begin
                  state_d = ST_HOLD_HI;
                  hold_d  = HOLD_LOAD;
                  issue_s = 1'b1;
                  pend_d  = in_s1;
               end else begin
                  state_d = ST_LOW;
                  pend_d  = 1'b0;
               end
            end else begin
               hold_d = hold_q - HOLD_ONE;
               if (pend_q) begin
                  drop_s = in_s0 | in_s1;
               end else begin
                  pend_d = in_s0;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
            hold_d  = HOLD_ZERO;
            pend_d  = 1'b0;
         end
      endcase
   end

   // Output logic: next values of the registered outputs from the next state
   always_comb begin
      out_s_d    = (state_d == ST_HOLD_HI) || (state_d == ST_HIGH);
      busy_d     = (state_d == ST_HOLD_HI) || (state_d == ST_HOLD_LO);
      err_drop_d = drop_s;
      if (issue_s) begin
         edge_cnt_d = edge_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         edge_cnt_d = edge_cnt_q;
      end
   end

   assign out_s    = out_s_q;
   assign busy     = busy_q;
   assign err_drop = err_drop_q;
   assign edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_edge_level_gen.sv
// Directed bench for edge_level_gen (MIN_HOLD=4, INIT_LEVEL=0, CNT_W=8).
module tb_edge_level_gen;

   logic       clk;
   logic       rst_n;
   logic       in_s0;
   logic       in_s1;
   logic       out_s;
   logic       busy;
   logic       err_drop;
   logic [7:0] edge_cnt;

   int         checks;
   int         failures;
   logic [7:0] exp_cnt;

   edge_level_gen #(.MIN_HOLD(4), .INIT_LEVEL(1'b0), .CNT_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_s0    (in_s0),
      .in_s1    (in_s1),
      .out_s    (out_s),
      .busy     (busy),
      .err_drop (err_drop),
      .edge_cnt (edge_cnt)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // apply inputs for one cycle, then observe 1 ns after the sampling edge
   task automatic tick(input logic a, input logic b);
      in_s0 = a;
      in_s1 = b;
      @(posedge clk);
      #1;
      in_s0 = 1'b0;
      in_s1 = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_s0 = 1'b1;
         @(posedge clk);
         #1;
      end
      in_s0 = 1'b0;
      checks++; if (out_s !== 1'b0) begin failures++; $display("FAIL reset_out actual=%b expected=0", out_s); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", busy); end
      checks++; if (edge_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt actual=%0d expected=0", edge_cnt); end
      checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL reset_err actual=%b expected=0", err_drop); end
      rst_n = 1'b1;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      exp_cnt = 8'd0;
   endtask

   task automatic test_single_rise;
      tick(1'b1, 1'b0);
      exp_cnt = exp_cnt + 8'd1;
      checks++; if (out_s !== 1'b1) begin failures++; $display("FAIL rise_out actual=%b expected=1", out_s); end
      checks++; if (edge_cnt !== exp_cnt) begin failures++; $display("FAIL rise_cnt actual=%0d expected=%0d", edge_cnt, exp_cnt); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rise_busy_%0d actual=%b expected=1", i, busy); end
         tick(1'b0, 1'b0);
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rise_busy_end actual=%b expected=0", busy); end
      checks++; if (out_s !== 1'b1) begin failures++; $display("FAIL rise_level actual=%b expected=1", out_s); end
      // return to LOW
      tick(1'b0, 1'b1);
      exp_cnt = exp_cnt + 8'd1;
      checks++; if (out_s !== 1'b0) begin failures++; $display("FAIL fall_out actual=%b expected=0", out_s); end
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
      checks++; if (edge_cnt !== exp_cnt) begin failures++; $display("FAIL fall_cnt actual=%0d expected=%0d", edge_cnt, exp_cnt); end
   endtask

   task automatic test_pulse;
      tick(1'b1, 1'b1);
      exp_cnt = exp_cnt + 8'd1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_s !== 1'b1) begin failures++; $display("FAIL pulse_high_%0d actual=%b expected=1", i, out_s); end
         checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL pulse_err_%0d actual=%b expected=0", i, err_drop); end
         tick(1'b0, 1'b0);
      end
      exp_cnt = exp_cnt + 8'd1;
      checks++; if (out_s !== 1'b0) begin failures++; $display("FAIL pulse_low actual=%b expected=0", out_s); end
      checks++; if (edge_cnt !== exp_cnt) begin failures++; $display("FAIL pulse_cnt actual=%0d expected=%0d", edge_cnt, exp_cnt); end
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pulse_idle actual=%b expected=0", busy); end
   endtask

   task automatic test_queue_drop;
      tick(1'b1, 1'b0);
      exp_cnt = exp_cnt + 8'd1;
      tick(1'b0, 1'b1);
      checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL queue_noerr actual=%b expected=0", err_drop); end
      tick(1'b1, 1'b0);
      checks++; if (err_drop !== 1'b1) begin failures++; $display("FAIL queue_drop actual=%b expected=1", err_drop); end
      checks++; if (out_s !== 1'b1) begin failures++; $display("FAIL queue_held actual=%b expected=1", out_s); end
      tick(1'b0, 1'b0);
      checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL queue_drop_end actual=%b expected=0", err_drop); end
      checks++; if (out_s !== 1'b1) begin failures++; $display("FAIL queue_held2 actual=%b expected=1", out_s); end
      tick(1'b0, 1'b0);
      exp_cnt = exp_cnt + 8'd1;
      checks++; if (out_s !== 1'b0) begin failures++; $display("FAIL queue_fall actual=%b expected=0", out_s); end
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
      checks++; if (out_s !== 1'b0) begin failures++; $display("FAIL queue_no_rise actual=%b expected=0", out_s); end
      checks++; if (edge_cnt !== exp_cnt) begin failures++; $display("FAIL queue_cnt actual=%0d expected=%0d", edge_cnt, exp_cnt); end
   endtask

   task automatic test_redundant;
      tick(1'b0, 1'b1);
      checks++; if (out_s !== 1'b0 || busy !== 1'b0 || err_drop !== 1'b0) begin failures++; $display("FAIL redundant_fall actual=%b%b%b expected=000", out_s, busy, err_drop); end
      tick(1'b1, 1'b0);
      exp_cnt = exp_cnt + 8'd1;
      tick(1'b1, 1'b0);
      checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL redundant_rise_err actual=%b expected=0", err_drop); end
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
      checks++; if (out_s !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL redundant_level actual=%b%b expected=10", out_s, busy); end
      checks++; if (edge_cnt !== exp_cnt) begin failures++; $display("FAIL redundant_cnt actual=%0d expected=%0d", edge_cnt, exp_cnt); end
      tick(1'b0, 1'b1);
      exp_cnt = exp_cnt + 8'd1;
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
   endtask

   task automatic test_back_to_back;
      tick(1'b1, 1'b1);
      exp_cnt = exp_cnt + 8'd1;
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
      // hold expires with fall queued; a rise arriving now becomes the new pending
      tick(1'b1, 1'b0);
      exp_cnt = exp_cnt + 8'd1;
      checks++; if (out_s !== 1'b0) begin failures++; $display("FAIL b2b_fall actual=%b expected=0", out_s); end
      checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL b2b_err actual=%b expected=0", err_drop); end
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
      checks++; if (out_s !== 1'b0) begin failures++; $display("FAIL b2b_lowhold actual=%b expected=0", out_s); end
      tick(1'b0, 1'b0);
      exp_cnt = exp_cnt + 8'd1;
      checks++; if (out_s !== 1'b1) begin failures++; $display("FAIL b2b_rise actual=%b expected=1", out_s); end
      checks++; if (edge_cnt !== exp_cnt) begin failures++; $display("FAIL b2b_cnt actual=%0d expected=%0d", edge_cnt, exp_cnt); end
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      exp_cnt = exp_cnt + 8'd1;
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_hold;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
      rst_n = 1'b0;
      tick(1'b0, 1'b0);
      rst_n = 1'b1;
      exp_cnt = 8'd0;
      checks++; if (out_s !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_state actual=%b%b expected=00", out_s, busy); end
      checks++; if (edge_cnt !== 8'd0) begin failures++; $display("FAIL midrst_cnt actual=%0d expected=0", edge_cnt); end
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
      checks++; if (out_s !== 1'b0 || edge_cnt !== 8'd0) begin failures++; $display("FAIL midrst_after actual=%b/%0d expected=0/0", out_s, edge_cnt); end
   endtask

   task automatic test_wrap;
      for (int p = 0; p < 128; p++) begin
         tick(1'b1, 1'b1);
         for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
         exp_cnt = exp_cnt + 8'd2;
         if (p == 0 || p == 127) begin
            checks++; if (edge_cnt !== exp_cnt) begin failures++; $display("FAIL wrap_cnt_%0d actual=%0d expected=%0d", p, edge_cnt, exp_cnt); end
         end
      end
      checks++; if (edge_cnt !== 8'd0) begin failures++; $display("FAIL wrap_zero actual=%0d expected=0", edge_cnt); end
      tick(1'b1, 1'b0);
      checks++; if (edge_cnt !== 8'd1) begin failures++; $display("FAIL wrap_continue actual=%0d expected=1", edge_cnt); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      exp_cnt  = 8'd0;
      rst_n    = 1'b0;
      in_s0    = 1'b0;
      in_s1    = 1'b0;
      #5;
      test_reset;
      test_single_rise;
      test_pulse;
      test_queue_drop;
      test_redundant;
      test_back_to_back;
      test_reset_mid_hold;
      test_wrap;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
